// File: rtl/fp_mul_seq_if.sv
// Operand/result bundle for the sequential single-precision multiplier.
// Handshake: start is a one-cycle request taken only while the core is idle. busy covers the
// multiply and normalise phases. out_valid pulses once per accepted request. result/ovf/unf stay
// stable until the next accepted start. There is no backpressure and no queueing.
interface fp_mul_seq_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              busy;
    logic              out_valid;
    logic [WORD_W-1:0] result;
    logic              ovf;
    logic              unf;

    modport master (
        output start, op_a, op_b,
        input  busy, out_valid, result, ovf, unf
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, out_valid, result, ovf, unf
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: radix-2 shift-add significand product,
// one-step normalisation, truncation and special-case override. The latency is fixed for all inputs.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    fp_mul_seq_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int WORD_W = 1 + EXP_W + MAN_W;
    localparam int E_W    = EXP_W + 2;
    localparam int CNT_W  = $clog2(SIG_W);

    localparam logic [EXP_W-1:0]      EXP_ONES = {EXP_W{1'b1}};
    localparam logic signed [E_W-1:0] E_SAT    = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ZERO   = '0;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SIG_W - 1);
    localparam logic [WORD_W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                    sign_q;
    logic signed [E_W-1:0]   e_sum_q;
    logic [PROD_W-1:0]       mcand_q;
    logic [SIG_W-1:0]        mplier_q;
    logic [PROD_W-1:0]       acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    invalid_q;
    logic                    inf_q;
    logic                    zero_q;
    logic [WORD_W-1:0]       result_q;
    logic                    ovf_q;
    logic                    unf_q;

    // Operand field decode, used only on the accepting edge.
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [E_W-1:0]   e_sum_in;

    assign ea = bus.op_a[WORD_W-2 -: EXP_W];
    assign eb = bus.op_b[WORD_W-2 -: EXP_W];
    assign fa = bus.op_a[MAN_W-1:0];
    assign fb = bus.op_b[MAN_W-1:0];

    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    assign e_sum_in = E_W'(ea) + E_W'(eb) - E_W'(BIAS);

    // Control FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = MULT;
            MULT:    if (cnt_q == CNT_LAST) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Normalisation and special-case resolution; registered on the NORM -> DONE edge.
    logic                  prod_hi;
    logic [MAN_W-1:0]      frac_n;
    logic signed [E_W-1:0] e_norm;
    logic [WORD_W-1:0]     res_d;
    logic                  ovf_d;
    logic                  unf_d;

    assign prod_hi = acc_q[PROD_W-1];
    assign frac_n  = prod_hi ? acc_q[PROD_W-2 -: MAN_W] : acc_q[PROD_W-3 -: MAN_W];
    assign e_norm  = e_sum_q + $signed({{(E_W-1){1'b0}}, prod_hi});

    always_comb begin
        res_d = {sign_q, e_norm[EXP_W-1:0], frac_n};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (invalid_q) begin
            res_d = QNAN;
        end else if (inf_q) begin
            res_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (zero_q) begin
            res_d = {sign_q, {(WORD_W-1){1'b0}}};
        end else if (e_norm >= E_SAT) begin
            res_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (e_norm <= E_ZERO) begin
            res_d = {sign_q, {(WORD_W-1){1'b0}}};
            unf_d = 1'b1;
        end
    end

    // Datapath: operand capture, LSB-first shift-add, result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q    <= 1'b0;
            e_sum_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sign_q    <= bus.op_a[WORD_W-1] ^ bus.op_b[WORD_W-1];
                        e_sum_q   <= e_sum_in;
                        mcand_q   <= {{(PROD_W-SIG_W){1'b0}}, 1'b1, fa};
                        mplier_q  <= {1'b1, fb};
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        invalid_q <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                        inf_q     <= a_inf | b_inf;
                        zero_q    <= a_zero | b_zero;
                    end
                end
                MULT: begin
                    acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                NORM: begin
                    result_q <= res_d;
                    ovf_q    <= ovf_d;
                    unf_q    <= unf_d;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (state_q == MULT) || (state_q == NORM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign dbg_state     = state_q;

endmodule
